prio_rr_arbiter: RTL and testbench
==================================

Name: prio_rr_arbiter

Overview:
- Sequential 4-requester arbiter built around the team's 4-input priority selection (p3 highest).
- Shares one downstream resource among requesters 0..3.
- Two modes: fixed priority (index 3 highest) or round-robin. The grant is held until the owner releases it, drops its request, or a hold timeout fires.
- Sits between requesting agents and the shared resource. Emits a one-hot grant plus an encoded owner ID.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release; 0 disables the timeout.
- CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request vector; bit i = requester i.
- rel  input  1  release pulse from the current owner.
- mode  input  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE.
- gnt  output  4  one-hot grant, or all-zero.
- gnt_id  output  2  encoded owner index; valid when gnt_valid = 1.
- gnt_valid  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (async assert, sync deassert by flop design):
  - gnt = 0000, gnt_id = 0, gnt_valid = 0, timeout = 0.
  - State = IDLE, hold counter = 0, rr pointer last_id = 3.
- All outputs are registered.
- States: IDLE, GRANT.
- IDLE:
  - If req == 0, remain in IDLE.
  - Otherwise select a winner and go to GRANT. gnt, gnt_id and gnt_valid are asserted on the next edge, so latency from req to gnt is 1 cycle.
  - Fixed mode: winner = highest set index (3 > 2 > 1 > 0).
  - RR mode: search ascending from (last_id+1) mod 4 with wrap; first set bit wins.
- GRANT:
  - Outputs hold stable.
  - Hold counter increments each cycle from 0.
  - Exit to IDLE on the next edge if any of:
    - rel = 1;
    - req[gnt_id] = 0 (owner dropped its request; treated as release);
    - MAX_HOLD != 0 and counter == MAX_HOLD-1.
  - On exit: gnt = 0000, gnt_valid = 0, counter = 0, last_id = gnt_id (both modes).
- Timeout:
  - timeout pulses high for exactly the cycle gnt drops, only when the exit cause is the counter alone.
  - If rel or a request drop coincides with the timeout, there is no timeout pulse.
- Gap: at least one IDLE cycle with gnt = 0 between consecutive grants. Back-to-back release to new grant is therefore 2 cycles.
- Requests from non-owners during GRANT are ignored and not queued; they are re-evaluated in IDLE.
- rel asserted in IDLE is ignored.
- mode changes during GRANT take effect at the next IDLE evaluation.
- gnt_id holds its last value while gnt_valid = 0, and is 0 after reset.
- An rst_n assertion mid-grant immediately clears all outputs. The rr pointer returns to 3, so the first rr search after reset starts at 0.
- Invariants: gnt is always one-hot or zero; gnt_valid == |gnt; gnt == (1 << gnt_id) whenever gnt_valid = 1.

Decomposition:
- Package arb_pkg holds:
  - N_REQ = 4, ID_W = 2;
  - state enum {IDLE, GRANT};
  - a typedef for the request vector.
- One natural sub-module: prio_pick4. It is combinational: inputs are req[3:0], mode and start index; outputs are winner id and any-flag. It is reused for both fixed and rr searches.
- The FSM, hold counter and pointer live in the top module.

Test Plan:
- Reset / fixed priority: rst_n low then high, mode=0, req=1111 → after 1 cycle gnt=1000, gnt_id=3; pulse rel → gnt=0000 next cycle; with req still 1111 → gnt=1000 again 2 cycles after rel.
- RR rotation: mode=1, req=1111 held, rel pulsed each grant → successive gnt_id 0,1,2,3,0 with one idle cycle between each.
- Timeout: MAX_HOLD=4, mode=0, req=0100 held, no rel → gnt_id=2 for exactly 4 cycles, then gnt=0000 with timeout=1 for one cycle; regrant follows.
- Simultaneous rel at the timeout cycle: MAX_HOLD=4, rel in the 4th grant cycle → grant drops, timeout stays 0.
- Owner drop: mode=0, req=0011 → gnt_id=1; deassert req[1] → gnt=0000 next cycle, then gnt_id=0.
- Async reset mid-grant: during gnt=0010, pulse rst_n low asynchronously mid-cycle → outputs go to 0 without waiting for an edge; with mode=1 and req=1111 after reset, the first grant is gnt_id=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizes for the 4-requester priority / round-robin arbiter.
package arb_pkg;
   localparam int N_REQ = 4;
   localparam int ID_W  = 2;

   typedef enum logic {IDLE, GRANT} state_t;
   typedef logic [N_REQ-1:0] req_vec_t;

   function automatic req_vec_t id_to_onehot(input logic [ID_W-1:0] id);
      req_vec_t v;
      v = '0;
      v[id] = 1'b1;
      return v;
   endfunction
endpackage

// File: rtl/prio_pick4.sv
// Combinational winner selection: highest index in fixed mode, or first set
// bit searching upward from start (with wrap) in round-robin mode.
module prio_pick4
   import arb_pkg::*;
(
   input  req_vec_t            req,
   input  logic                mode,
   input  logic [ID_W-1:0]     start,
   output logic [ID_W-1:0]     id,
   output logic                any
);

   logic [ID_W-1:0] idx;

   always_comb begin
      id  = '0;
      idx = '0;
      any = |req;
      if (!mode) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (req[i]) id = ID_W'(i);
         end
      end else begin
         // Walk the search order backwards so the nearest candidate is written last.
         for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = start + ID_W'(k);
            if (req[idx]) id = idx;
         end
      end
   end

endmodule

// File: rtl/prio_rr_arbiter.sv
// Sequential 4-requester arbiter: grant held until release, owner drop or
// hold timeout; mode selects fixed priority or round-robin at each IDLE pick.
//
// state | meaning
// IDLE  | no owner; evaluate req and pick a winner
// GRANT | owner holds the resource; hold counter runs
module prio_rr_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req,
   input  logic             rel,
   input  logic             mode,
   output logic [3:0]       gnt,
   output logic [1:0]       gnt_id,
   output logic             gnt_valid,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

   state_t           state;
   logic [CNT_W-1:0] hold_cnt;
   logic [ID_W-1:0]  last_id;
   logic [ID_W-1:0]  pick_id;
   logic             pick_any;
   logic             owner_drop;
   logic             hold_done;
   logic             release_now;

   prio_pick4 u_pick (
      .req   (req),
      .mode  (mode),
      .start (last_id + ID_W'(1)),
      .id    (pick_id),
      .any   (pick_any)
   );

   always_comb begin
      owner_drop  = ~req[gnt_id];
      hold_done   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
      release_now = rel | owner_drop | hold_done;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         hold_cnt  <= '0;
         last_id   <= ID_W'(N_REQ - 1);
         gnt       <= '0;
         gnt_id    <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  state     <= GRANT;
                  gnt       <= id_to_onehot(pick_id);
                  gnt_id    <= pick_id;
                  gnt_valid <= 1'b1;
                  hold_cnt  <= '0;
               end
            end
            GRANT: begin
               if (release_now) begin
                  state     <= IDLE;
                  gnt       <= '0;
                  gnt_valid <= 1'b0;
                  hold_cnt  <= '0;
                  last_id   <= gnt_id;
                  // Only a pure counter expiry counts as a forced release.
                  timeout   <= hold_done & ~rel & ~owner_drop;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Scoreboard bench for prio_rr_arbiter: a per-cycle reference model pushes the
// expected outputs, and a monitor pops and compares them after each edge.
module tb_prio_rr_arbiter;
   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = '0;
   logic       rel = 1'b0;
   logic       mode = 1'b0;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] id;
      logic       valid;
      logic       timeout;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // reference model state: owner (-1 = none), cycles held, last owner, shown id
   int m_owner = -1;
   int m_held  = 0;
   int m_last  = 3;
   int m_id    = 0;

   prio_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .rel       (rel),
      .mode      (mode),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_pick(input logic [3:0] r, input logic m);
      if (!m) begin
         for (int i = 3; i >= 0; i--) if (r[i]) return i;
      end else begin
         for (int k = 1; k <= 4; k++) if (r[(m_last + k) % 4]) return (m_last + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_last  = 3;
      m_id    = 0;
   endtask

   task automatic step(input logic [3:0] r, input logic rl, input logic m);
      exp_t e;
      bit   expired;
      e = '0;
      @(negedge clk);
      req = r; rel = rl; mode = m;
      if (m_owner < 0) begin
         if (r != 4'b0000) begin
            m_owner = model_pick(r, m);
            m_held  = 1;
            m_id    = m_owner;
         end
      end else begin
         expired = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
         if (rl || !r[m_owner] || expired) begin
            e.timeout = expired && !rl && r[m_owner];
            m_last  = m_owner;
            m_owner = -1;
         end else begin
            m_held++;
         end
      end
      e.valid = (m_owner >= 0);
      e.gnt   = e.valid ? (4'b0001 << m_owner) : 4'b0000;
      e.id    = m_id[1:0];
      sb.push_back(e);
   endtask

   task automatic reset_mid_cycle();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      req = '0; rel = 1'b0;
      #1;
      check("async_rst_gnt", gnt, 4'b0000);
      check("async_rst_id", {2'b00, gnt_id}, 4'd0);
      check("async_rst_valid", {3'b000, gnt_valid}, 4'd0);
      check("async_rst_timeout", {3'b000, timeout}, 4'd0);
      model_reset();
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("gnt", gnt, e.gnt);
            check("gnt_valid", {3'b000, gnt_valid}, {3'b000, e.valid});
            check("gnt_id", {2'b00, gnt_id}, {2'b00, e.id});
            check("timeout", {3'b000, timeout}, {3'b000, e.timeout});
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic m_rand;
      #3;
      check("rst_gnt", gnt, 4'b0000);
      check("rst_id", {2'b00, gnt_id}, 4'd0);
      check("rst_valid", {3'b000, gnt_valid}, 4'd0);
      check("rst_timeout", {3'b000, timeout}, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // fixed priority, release and regrant
      for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b0);
      step(4'b1111, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);

      // round-robin rotation with release on every grant
      for (int i = 0; i < 12; i++) step(4'b1111, (m_owner >= 0), 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);

      // pure timeout
      for (int i = 0; i < 13; i++) step(4'b0100, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);

      // rel coincides with the timeout cycle
      for (int i = 0; i < 8; i++) step(4'b0100, (m_owner >= 0 && m_held == MAX_HOLD), 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);

      // owner drops its request
      for (int i = 0; i < 3; i++) step(4'b0011, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(4'b0001, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);

      // async reset mid-grant, then rr restarts from requester 0
      step(4'b0010, 1'b0, 1'b0);
      step(4'b0010, 1'b0, 1'b0);
      reset_mid_cycle();
      for (int i = 0; i < 6; i++) step(4'b1111, 1'b0, 1'b1);

      // randomized traffic
      m_rand = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) m_rand = ~m_rand;
         step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), m_rand);
      end
      step(4'b0000, 1'b0, 1'b0);

      @(posedge clk);
      @(posedge clk);
      #2;
      check("sb_drained", 4'(sb.size()), 4'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
